// File: rtl/dmem_responder_if.sv
// Core-to-data-memory port: request/response bus plus write-buffer status.
interface dmem_responder_if #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int WBUF_DEPTH = 4
);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              fence_i;
  logic              wbuf_empty;
  logic [CW-1:0]     wbuf_count;
  logic              addr_err;

  modport master (
    output mem_ce, mem_we, mem_raddr, mem_waddr, mem_wdata, fence_i,
    input  mem_rdata, wbuf_empty, wbuf_count, addr_err
  );

  modport slave (
    input  mem_ce, mem_we, mem_raddr, mem_waddr, mem_wdata, fence_i,
    output mem_rdata, wbuf_empty, wbuf_count, addr_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: combinational reads, in-order write buffer drained
// into a word array when idle/fenced/full, with youngest-entry read forwarding.
module dmem_responder #(
  parameter int                DATA_W     = 64,
  parameter int                ADDR_W     = 64,
  parameter int                IDX_W      = 12,
  parameter logic [ADDR_W-1:0] BASE       = 'h8000_0000,
  parameter int                WBUF_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave mem
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_mem [0:(2**IDX_W)-1];
  logic [IDX_W-1:0]  r_idx [0:WBUF_DEPTH-1];
  logic [DATA_W-1:0] r_dat [0:WBUF_DEPTH-1];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_err;

  logic [ADDR_W-1:0] w_roff, w_woff, w_rword, w_wword;
  logic              w_rin, w_win;
  logic [IDX_W-1:0]  w_ridx, w_widx;
  logic              w_rd, w_wr, w_push, w_pop, w_full;
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd;
  logic [PW-1:0]     w_pos;

  assign w_roff  = mem.mem_raddr - BASE;
  assign w_woff  = mem.mem_waddr - BASE;
  assign w_rword = w_roff >> 3;
  assign w_wword = w_woff >> 3;
  assign w_rin   = (mem.mem_raddr >= BASE) && ((w_rword >> IDX_W) == '0);
  assign w_win   = (mem.mem_waddr >= BASE) && ((w_wword >> IDX_W) == '0);
  assign w_ridx  = w_rword[IDX_W-1:0];
  assign w_widx  = w_wword[IDX_W-1:0];

  assign w_rd   = mem.mem_ce && !mem.mem_we;
  assign w_wr   = mem.mem_ce && mem.mem_we;
  assign w_full = (r_count == CW'(WBUF_DEPTH));
  assign w_push = w_wr && w_win;
  // A full buffer always pops alongside an in-range push, so it never overflows.
  assign w_pop  = (r_count != '0) && (!mem.mem_ce || mem.fence_i || (w_full && w_push));

  // Scan oldest to youngest so the last match found is the youngest entry.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_pos = '0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      w_pos = r_head + PW'(i);
      if ((i < 32'(r_count)) && (r_idx[w_pos] == w_ridx)) begin
        w_hit = 1'b1;
        w_fwd = r_dat[w_pos];
      end
    end
  end

  assign mem.mem_rdata  = (w_rd && w_rin) ? (w_hit ? w_fwd : r_mem[w_ridx]) : '0;
  assign mem.wbuf_count = r_count;
  assign mem.wbuf_empty = (r_count == '0);
  assign mem.addr_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if ((w_rd && !w_rin) || (w_wr && !w_win)) r_err <= 1'b1;
    end
  end

  // Storage is deliberately unreset: array contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_idx[r_tail] <= w_widx;
      r_dat[r_tail] <= mem.mem_wdata;
    end
    if (w_pop) r_mem[r_idx[r_head]] <= r_dat[r_head];
  end
endmodule
